uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_BIT, default 434, meaning clocks per UART bit; it SHALL match the transmitter's per-bit cycle count.
REQ-002 The block SHALL define derived constant FRAME_CYCLES = 10*CYCLES_PER_BIT + 2, meaning one 10-bit frame plus 2 cycles of transmitter input-register latency.
REQ-003 clk  input  1  system clock.
REQ-004 r_reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 i_req_valid  input  4  per-requester byte-valid; bit k belongs to requester k.
REQ-006 i_req_data  input  32  per-requester byte; requester k on bits [8k+7:8k].
REQ-007 o_req_ready  output  4  one-hot accept strobe; a byte transfers when valid and ready are both high on the same bit.
REQ-008 o_tx_data  output  8  byte presented to the transmitter data input.
REQ-009 o_tx_start  output  1  single-cycle start pulse to the transmitter.
REQ-010 o_busy  output  1  high whenever the state is not IDLE.
REQ-011 o_grant_id  output  2  index of the requester whose byte is currently in flight.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, START and WAIT.
REQ-013 In IDLE with any i_req_valid bit high, the block SHALL combinationally assert exactly one o_req_ready bit, for the round-robin winner.
REQ-014 Round-robin search SHALL start at (r_last_grant+1) mod 4 and proceed upward with wrap-around; the first valid requester wins.
REQ-015 On accept, the block SHALL register the winner's byte into r_byte, the winner index into r_last_grant and o_grant_id, and move to START.
REQ-016 In IDLE with no valid bits, o_req_ready SHALL be 0000 and the state SHALL stay IDLE.
REQ-017 In START, o_tx_start SHALL be 1 for exactly one cycle; the next state SHALL be WAIT, with the frame counter cleared to 0.
REQ-018 In WAIT, the counter SHALL increment by 1 each cycle; when counter == FRAME_CYCLES-1, the next state SHALL be IDLE.
REQ-019 WAIT SHALL therefore last exactly FRAME_CYCLES cycles, and back-to-back accepts SHALL be FRAME_CYCLES+2 cycles apart.
REQ-020 The counter SHALL be wide enough to hold FRAME_CYCLES-1 with no wrap; the counter SHALL never exceed FRAME_CYCLES-1.
REQ-021 o_tx_data SHALL equal r_byte and stay stable from START through the last WAIT cycle.
REQ-022 o_req_ready SHALL be 0000 in START and WAIT, whatever i_req_valid is.
REQ-023 A requester that drops valid before being accepted SHALL lose nothing and leave no state behind; a requester that holds valid SHALL be served within 4 grants.
REQ-024 i_req_valid changes during START or WAIT SHALL have no effect until the next IDLE cycle.
REQ-025 o_tx_start SHALL never be asserted outside START, and SHALL never occur twice within one frame.

Reset
REQ-026 While r_reset is high at a clk edge, the next state SHALL be IDLE, the counter 0, r_byte 0x00, o_grant_id 0 and r_last_grant 3, so that requester 0 has top priority.
REQ-027 During reset, o_tx_start, o_busy and o_req_ready SHALL all be 0.
REQ-028 Reset asserted mid-START or mid-WAIT SHALL abort the frame at once with no further start pulse; the parent resets the transmitter at the same time.

Verification (CYCLES_PER_BIT=4, FRAME_CYCLES=42)
REQ-029 Reset, then hold only valid[2] with byte 0xA5 from cycle t -> o_req_ready=0100 at t; o_tx_start=1 and o_tx_data=0xA5 at t+1; o_busy high t+1..t+43; IDLE at t+44.
REQ-030 All four valid from t, held -> grants in order 0,1,2,3,0, with accepts at t, t+44, t+88, t+132, t+176.
REQ-031 Only requesters 1 and 3 valid, with r_last_grant=1 -> requester 3 is granted first, then 1 (wrap-around).
REQ-032 valid[0] is raised during WAIT and dropped before IDLE -> no ready and no start pulse for requester 0.
REQ-033 r_reset is pulsed at WAIT counter 20 -> next cycle IDLE, o_busy=0; the next grant goes to the lowest-index valid requester.
REQ-034 Every run -> exactly one o_tx_start per accept, and o_tx_data is stable across each frame.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler_if
//  Description : Requester / transmitter handshake bundle for the UART TX
//                scheduler. The master side is the requester and transmitter
//                environment; the slave side is the scheduler itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_scheduler_if;

    // Four requesters: valid bit k and byte lane [8k+7:8k] belong to requester k.
    logic [3:0]  i_req_valid;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;

    // Transmitter side and status.
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic [1:0]  o_grant_id;

    modport master (
        output i_req_valid,
        output i_req_data,
        input  o_req_ready,
        input  o_tx_data,
        input  o_tx_start,
        input  o_busy,
        input  o_grant_id
    );

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        output o_req_ready,
        output o_tx_data,
        output o_tx_start,
        output o_busy,
        output o_grant_id
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Round-robin scheduler feeding bytes from four requesters to a
//                single UART transmitter. One byte is accepted in IDLE, a
//                one-cycle start pulse is issued in START, and WAIT holds the
//                byte for a full frame before the next arbitration.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int CYCLES_PER_BIT = 434
) (
    input  wire logic          clk,
    input  wire logic          r_reset,
    uart_tx_scheduler_if.slave bus
);

    // One 10-bit frame plus the transmitter's two-cycle input-register latency.
    localparam int FRAME_CYCLES = 10 * CYCLES_PER_BIT + 2;

    // Counter only has to reach FRAME_CYCLES-1, so clog2(FRAME_CYCLES) bits suffice.
    localparam int              CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [7:0]        r_byte;
    logic [1:0]        r_last_grant;
    logic [1:0]        grant_id_q;

    logic              win_found;
    logic [1:0]        win_idx;
    logic [3:0]        ready_d;
    logic              accept;
    logic              start_d;

    // Round-robin search: begin one past the last grant and wrap upward; the
    // previous winner is therefore examined last.
    always_comb begin
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int off = 1; off <= 4; off++) begin
            cand = r_last_grant + 2'(off);
            if (!win_found && bus.i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state, frame counter and handshake strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 4'b0000;
        accept  = 1'b0;
        start_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    ready_d = 4'b0001 << win_idx;
                    accept  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any frame in flight and makes requester 0
    // the first candidate by parking the last grant at 3.
    always_ff @(posedge clk) begin
        if (r_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            r_byte       <= 8'h00;
            r_last_grant <= 2'd3;
            grant_id_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                r_byte       <= bus.i_req_data[{win_idx, 3'b000} +: 8];
                r_last_grant <= win_idx;
                grant_id_q   <= win_idx;
            end
        end
    end

    // Strobes and status are forced low while reset is held so nothing leaks
    // out of an aborted frame.
    assign bus.o_req_ready = r_reset ? 4'b0000 : ready_d;
    assign bus.o_tx_start  = start_d & ~r_reset;
    assign bus.o_busy      = (state_q != IDLE) & ~r_reset;
    assign bus.o_tx_data   = r_byte;
    assign bus.o_grant_id  = grant_id_q;

endmodule
`default_nettype wire
